// File: rtl/bcd_display_driver_if.sv
// Bus between counter/score logic and the BCD display driver.
// The master supplies value/load/enable; the slave returns segments and status.
interface bcd_display_driver_if #(
    parameter int VALUE_W = 6,
    parameter int DIGITS  = 2
);
    logic [VALUE_W-1:0]  value;
    logic                load;
    logic                enable;
    logic [7*DIGITS-1:0] hex;
    logic                busy;
    logic                done;
    logic                ovf;

    modport master (output value, load, enable, input hex, busy, done, ovf);
    modport slave  (input value, load, enable, output hex, busy, done, ovf);
endinterface

// File: rtl/bcd_display_driver.sv
// Binary to BCD conversion (shift-and-add-3) driving DIGITS active-low
// seven-segment digits, with saturation, leading-zero blanking and blink.
//
// state  | meaning
// IDLE   | waiting for load; display holds last committed value
// SHIFT  | one add-3/shift step per cycle, VALUE_W steps
// COMMIT | write scratch (or all nines on overflow) to display register
module bcd_display_driver #(
    parameter int VALUE_W     = 6,
    parameter int DIGITS      = 2,
    parameter int BLINK_BELOW = 3,
    parameter int BLINK_DIV   = 25_000_000,
    parameter int LZB         = 0
) (
    input logic clk,
    input logic rst,
    bcd_display_driver_if.slave bus
);
    localparam int SW = 4*DIGITS + 4;
    localparam int CW = $clog2(VALUE_W + 1);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int XW = VALUE_W + 64;

    function automatic logic [XW-1:0] disp_max();
        logic [XW-1:0] p;
        p = XW'(1);
        for (int i = 0; i < DIGITS; i++) p = p * XW'(10);
        return p - XW'(1);
    endfunction

    localparam logic [XW-1:0] DISP_MAX = disp_max();

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b0000001;
            4'd1:    glyph = 7'b1001111;
            4'd2:    glyph = 7'b0010010;
            4'd3:    glyph = 7'b0000110;
            4'd4:    glyph = 7'b1001100;
            4'd5:    glyph = 7'b0100100;
            4'd6:    glyph = 7'b0100000;
            4'd7:    glyph = 7'b0001111;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0000100;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [VALUE_W-1:0]  sr_q, sr_d;
    logic [SW-1:0]       scr_q, scr_d;
    logic [VALUE_W-1:0]  val_q, val_d;
    logic [VALUE_W-1:0]  blink_val_q, blink_val_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;
    logic [BW-1:0]       blk_cnt_q, blk_cnt_d;
    logic                phase_q, phase_d;

    logic [SW-1:0]       adj;
    logic                lead;
    logic [3:0]          nib;
    logic                blk_wrap;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        scr_d       = scr_q;
        val_d       = val_q;
        blink_val_d = blink_val_q;
        disp_d      = disp_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;

        adj = scr_q;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    val_d   = bus.value;
                    sr_d    = bus.value;
                    scr_d   = '0;
                    cnt_d   = CW'(VALUE_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, sr_d} = {adj, sr_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = COMMIT;
            end
            COMMIT: begin
                if (XW'(val_q) > DISP_MAX) begin
                    disp_d = {DIGITS{4'd9}};
                    ovf_d  = 1'b1;
                end else begin
                    disp_d = scr_q[4*DIGITS-1:0];
                    ovf_d  = 1'b0;
                end
                blink_val_d = val_q;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        blk_wrap  = (blk_cnt_q == BW'(BLINK_DIV - 1));
        blk_cnt_d = blk_wrap ? '0 : blk_cnt_q + BW'(1);
        phase_d   = blk_wrap ? ~phase_q : phase_q;
    end

    // Leading-zero scan runs from the most significant digit down; units always shown.
    always_comb begin
        hex_d = '1;
        lead  = 1'b1;
        nib   = '0;
        if (bus.enable && !((XW'(blink_val_q) < XW'(BLINK_BELOW)) && !phase_q)) begin
            for (int i = DIGITS - 1; i >= 0; i--) begin
                nib = disp_q[4*i +: 4];
                if (LZB != 0 && lead && nib == 4'd0 && i != 0) begin
                    hex_d[7*i +: 7] = 7'b1111111;
                end else begin
                    hex_d[7*i +: 7] = glyph(nib);
                    lead = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            scr_q       <= '0;
            val_q       <= '0;
            blink_val_q <= '0;
            disp_q      <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            hex_q       <= '1;
            blk_cnt_q   <= '0;
            phase_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            scr_q       <= scr_d;
            val_q       <= val_d;
            blink_val_q <= blink_val_d;
            disp_q      <= disp_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            hex_q       <= hex_d;
            blk_cnt_q   <= blk_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign bus.hex  = hex_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Parametrised successor to the team's two-digit seven-segment display decoder. It accepts a binary value through a load strobe and converts it to BCD over several cycles with a shift-and-add-3 engine. It then drives `DIGITS` active-low seven-segment digits from registered outputs. Added over the previous generation:
- arbitrary digit count and value width;
- saturation on overflow;
- optional leading-zero blanking;
- an internally generated blink for small values (replacing the external blink clock).

It sits between counter/score logic and the board's HEX displays.

## Interface
Parameters:
- `VALUE_W`, 6: width of the binary input value.
- `DIGITS`, 2: number of decimal digits driven.
- `BLINK_BELOW`, 3: captured values strictly below this blink; 0 disables blinking.
- `BLINK_DIV`, 25_000_000: clock cycles per blink half-period, must be ≥ 1.
- `LZB`, 0: 1 blanks leading zeros; the units digit is never blanked.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `value`  in  VALUE_W: binary value, sampled only on an accepted load.
- `load`  in  1: conversion request, accepted when `busy`=0.
- `enable`  in  1: 0 blanks all digits; does not stop conversion or the blink counter.
- `hex`  out  7*DIGITS: segments, registered; `hex[6:0]` is units, `hex[13:7]` is tens, and so on. Bit 6 = a … bit 0 = g, active low.
- `busy`  out  1: conversion in progress.
- `done`  out  1: one-cycle pulse when a new value reaches the display register.
- `ovf`  out  1: the last accepted value exceeded 10^DIGITS−1; held until the next accepted load.

## Operation
- Reset: `hex` all ones (blank), `busy`=0, `done`=0, `ovf`=0. Display BCD register = 0, captured value = 0, blink counter = 0, blink phase = on.
- Glyphs (abcdefg, active low):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - blank = 1111111
- States:
  - IDLE: `load`=1 captures `value` into the shift register, clears the BCD scratch, sets bit counter = VALUE_W, goes to SHIFT.
  - SHIFT: each cycle, add 3 to every scratch nibble ≥ 5, then shift {scratch, shift reg} left by 1 and decrement the counter. After VALUE_W shifts, go to COMMIT.
  - COMMIT (one cycle):
    - If the value is > 10^DIGITS−1, write all nines to the display register and set `ovf`=1; otherwise write the scratch and set `ovf`=0.
    - Latch the captured binary value for the blink compare.
    - Return to IDLE.
- Scratch width: 4*DIGITS + 4 guard bits, so overflow detection never aliases.
- `load` is ignored while `busy`=1; there is no queueing.
- Blink counter:
  - runs freely from reset, counting 0..BLINK_DIV−1;
  - on wrap, the blink phase toggles.
- Output each cycle, registered into `hex`:
  - if `enable`=0: all blank;
  - else if captured value < BLINK_BELOW and phase = off: all blank;
  - else: decoded digits, with leading zeros blanked when LZB=1.
- BCD nibbles above 9 cannot occur; the decoder's default arm outputs blank.

## Timing
- Load accepted at edge 0. `busy`=1 from after edge 0 through edge VALUE_W+1.
  - SHIFT occupies edges 1..VALUE_W.
  - COMMIT occurs at edge VALUE_W+1.
- At edge VALUE_W+1: display register and `ovf` update, `busy` falls.
- `done`=1 for the cycle after edge VALUE_W+1.
- `hex` reflects the new digits after edge VALUE_W+2; one register stage sits after the display register.
- Load-to-`done` latency: VALUE_W+1 cycles. Minimum load spacing: VALUE_W+2 cycles.
- A change on `enable` or in blink phase appears on `hex` one cycle later.
- `rst` asserted mid-conversion:
  - aborts the conversion and returns all state to its reset values;
  - no `done` pulse is produced;
  - a `load` in the same cycle as `rst` is ignored.

## Test plan
Bench parameters: VALUE_W=7, DIGITS=2, BLINK_BELOW=3, BLINK_DIV=4, LZB=0, with an LZB=1 instance where noted.

1. Hold `rst` 2 cycles → `hex`=14'h3FFF, `busy`=0, `done`=0, `ovf`=0.
2. `load` with value=42, `enable`=1 → `busy` high for 8 cycles, `done` pulses 8 cycles after load, then `hex[13:7]`=1001100 and `hex[6:0]`=0010010 steady with no blinking.
3. `load` with value=2 → `hex` alternates between {0000001, 0010010} and all-ones every 4 cycles. Then drop `enable` → all-ones one cycle later, while `done` behaviour is unchanged.
4. `load` with value=120 → `ovf`=1 and display shows 99 (0000100, 0000100). Next, load value=7 → `ovf`=0 and display shows 0000001, 0001111.
5. LZB=1 instance: `load` with value=5 → `hex[13:7]`=1111111, `hex[6:0]`=0100100. Then value=0 → units digit shows 0000001.
6. `load` value=42, then pulse `load` value=10 at cycle 3 → ignored, display ends at 42. Then `load` value=10 and assert `rst` at cycle 4 → no `done` pulse, all outputs return to reset values.
